// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, MEM-stage branch flushes,
// data-memory wait with timeout. Optional performance counters under macro HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int REG_AW      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              idex_memread,
  input  logic [REG_AW-1:0] idex_rt,
  input  logic              exmem_branch,
  input  logic              exmem_zero,
  input  logic              exmem_mem_req,
  input  logic              mem_ack,
  input  logic              err_clr,
  output logic              pc_en,
  output logic              pc_sel_branch,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_en,
  output logic              idex_flush,
  output logic              exmem_en,
  output logic              exmem_flush,
  output logic              mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       lu_stalls,
  output logic [31:0]       br_flushes
`endif
);

  localparam int            CW          = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [CW-1:0] TIMEOUT_CNT = CW'(MEM_TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, MEM_ERR} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          mem_err_q, mem_err_d;
  logic          load_use, br_taken, run_rules;

  assign load_use = idex_memread && (idex_rt != '0) &&
                    ((idex_rt == id_rs) || (idex_rt == id_rt));
  assign br_taken = exmem_branch && exmem_zero;

  // NOTE: every output and next-state variable gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_err_d     = mem_err_q;
    run_rules     = 1'b0;
    pc_en         = 1'b1;
    ifid_en       = 1'b1;
    idex_en       = 1'b1;
    exmem_en      = 1'b1;
    pc_sel_branch = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_flush   = 1'b0;

    case (state_q)
      RUN: begin
        if (exmem_mem_req && !mem_ack) begin
          {pc_en, ifid_en, idex_en, exmem_en} = '0;
          state_d    = MEM_WAIT;
          wait_cnt_d = CNT_ONE;
        end else begin
          run_rules = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          state_d    = RUN;
          wait_cnt_d = '0;
          run_rules  = 1'b1;
        end else begin
          {pc_en, ifid_en, idex_en, exmem_en} = '0;
          if (wait_cnt_q == TIMEOUT_CNT) begin
            state_d   = MEM_ERR;
            mem_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_ONE;
          end
        end
      end
      MEM_ERR: begin
        {pc_en, ifid_en, idex_en, exmem_en} = '0;
        if (err_clr) begin
          exmem_flush = 1'b1;  // drop the op that faulted
          mem_err_d   = 1'b0;
          state_d     = RUN;
          wait_cnt_d  = '0;
        end
      end
      default: state_d = RUN;
    endcase

    // A taken branch kills the instruction in ID, so its load-use match is moot.
    if (run_rules) begin
      if (br_taken) begin
        pc_sel_branch = 1'b1;
        ifid_flush    = 1'b1;
        idex_flush    = 1'b1;
        exmem_flush   = 1'b1;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end

    if (!rst) begin
      {pc_en, ifid_en, idex_en, exmem_en}   = '0;
      {ifid_flush, idex_flush, exmem_flush} = '1;
      pc_sel_branch                         = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_q, lu_q, br_q;

  // A bubble is the only case flushing ID/EX while IF/ID is kept; counters hold in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      lu_q    <= '0;
      br_q    <= '0;
    end else begin
      if (!pc_en)                    stall_q <= stall_q + 32'd1;
      if (idex_flush && !ifid_flush) lu_q    <= lu_q + 32'd1;
      if (pc_sel_branch)             br_q    <= br_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign lu_stalls    = lu_q;
  assign br_flushes   = br_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT=4): directed scenarios plus random
// traffic checked against a behavioural model of the pipeline-control rules.
module tb_pipe_hazard_ctrl;
  localparam int T  = 4;
  localparam int AW = 5;

  typedef struct packed {
    logic [AW-1:0] rs, rt;
    logic          mr;
    logic [AW-1:0] xrt;
    logic          br, z, req, ack, clr;
  } stim_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [AW-1:0] id_rs, id_rt, idex_rt;
  logic idex_memread, exmem_branch, exmem_zero, exmem_mem_req, mem_ack, err_clr;
  logic pc_en, pc_sel_branch, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, mem_err;
  logic [7:0] obs;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, lu_stalls, br_flushes;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(T), .REG_AW(AW)) dut (
    .clk(clk), .rst(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .idex_memread(idex_memread), .idex_rt(idex_rt),
    .exmem_branch(exmem_branch), .exmem_zero(exmem_zero),
    .exmem_mem_req(exmem_mem_req), .mem_ack(mem_ack), .err_clr(err_clr),
    .pc_en(pc_en), .pc_sel_branch(pc_sel_branch), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en), .exmem_flush(exmem_flush),
    .mem_err(mem_err)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .lu_stalls(lu_stalls), .br_flushes(br_flushes)
`endif
  );

  assign obs = {pc_en, pc_sel_branch, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush};

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Model: "waiting" counts elapsed memory-wait cycles, "errored" is the sticky timeout.
  bit          waiting, errored;
  int          waited;
  int unsigned m_stall, m_lu, m_br;

  function automatic bit hazard();
    return idex_memread && (idex_rt != 0) && (idex_rt == id_rs || idex_rt == id_rt);
  endfunction

  function automatic bit frozen();
    return errored || (waiting && !mem_ack) || (!waiting && exmem_mem_req && !mem_ack);
  endfunction

  function automatic logic [7:0] model_out();
    logic pc, sel, fe, ff, de, df, xe, xf;
    pc = 1; sel = 0; fe = 1; ff = 0; de = 1; df = 0; xe = 1; xf = 0;
    if (!rst_n) begin
      pc = 0; fe = 0; de = 0; xe = 0; ff = 1; df = 1; xf = 1;
    end else if (frozen()) begin
      pc = 0; fe = 0; de = 0; xe = 0;
      xf = errored && err_clr;
    end else if (exmem_branch && exmem_zero) begin
      sel = 1; ff = 1; df = 1; xf = 1;
    end else if (hazard()) begin
      pc = 0; fe = 0; df = 1;
    end
    return {pc, sel, fe, ff, de, df, xe, xf};
  endfunction

  task automatic model_tick();
    if (!rst_n) begin
      waiting = 0; errored = 0; waited = 0;
      m_stall = 0; m_lu = 0; m_br = 0;
      return;
    end
    if (frozen()) m_stall++;
    else if (exmem_branch && exmem_zero) m_br++;
    else if (hazard()) begin m_lu++; m_stall++; end
    if (errored) begin
      if (err_clr) begin errored = 0; waited = 0; end
    end else if (waiting) begin
      if (mem_ack) begin waiting = 0; waited = 0; end
      else if (waited == T) begin waiting = 0; errored = 1; end
      else waited++;
    end else if (exmem_mem_req && !mem_ack) begin
      waiting = 1; waited = 1;
    end
  endtask

  task automatic apply(input stim_t s);
    id_rs = s.rs; id_rt = s.rt; idex_memread = s.mr; idex_rt = s.xrt;
    exmem_branch = s.br; exmem_zero = s.z; exmem_mem_req = s.req; mem_ack = s.ack; err_clr = s.clr;
  endtask

  task automatic next_cycle();
    model_tick();
    @(negedge clk);
  endtask

  localparam stim_t IDLE = '0;

  task automatic test_reset();
    stim_t tbl[3];
    tbl[0] = IDLE;
    tbl[1] = '{rs:5'd5, rt:5'd0, mr:1'b1, xrt:5'd5, br:1'b1, z:1'b1, req:1'b1, ack:1'b0, clr:1'b1};
    tbl[2] = IDLE;
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      apply(tbl[i]);
      if (i == 2) rst_n = 1'b1;
      #1;
      total_cnt++;
      if ({obs, mem_err} !== {model_out(), errored})
        $display("FAIL reset[%0d]: got %b/%b exp %b/%b", i, obs, mem_err, model_out(), errored);
      else pass_cnt++;
      next_cycle();
    end
  endtask

  task automatic test_load_use();
    stim_t tbl[6];
    tbl[0] = '{rs:5'd5, rt:5'd0, mr:1'b1, xrt:5'd5, default:1'b0};
    tbl[1] = IDLE;
    tbl[2] = '{rs:5'd0, rt:5'd0, mr:1'b1, xrt:5'd0, default:1'b0};
    tbl[3] = '{rs:5'd3, rt:5'd7, mr:1'b1, xrt:5'd7, default:1'b0};
    tbl[4] = '{rs:5'd9, rt:5'd9, mr:1'b0, xrt:5'd9, default:1'b0};
    tbl[5] = IDLE;
    for (int i = 0; i < 6; i++) begin
      apply(tbl[i]);
      #1;
      total_cnt++;
      if ({obs, mem_err} !== {model_out(), errored})
        $display("FAIL load_use[%0d]: got %b/%b exp %b/%b", i, obs, mem_err, model_out(), errored);
      else pass_cnt++;
      next_cycle();
    end
  endtask

  task automatic test_branch();
    stim_t tbl[4];
    tbl[0] = '{rs:5'd5, rt:5'd0, mr:1'b1, xrt:5'd5, br:1'b1, z:1'b1, default:1'b0};
    tbl[1] = '{br:1'b1, z:1'b0, default:'0};
    tbl[2] = '{rs:5'd5, rt:5'd0, mr:1'b1, xrt:5'd5, br:1'b1, z:1'b0, default:1'b0};
    tbl[3] = IDLE;
    for (int i = 0; i < 4; i++) begin
      apply(tbl[i]);
      #1;
      total_cnt++;
      if ({obs, mem_err} !== {model_out(), errored})
        $display("FAIL branch[%0d]: got %b/%b exp %b/%b", i, obs, mem_err, model_out(), errored);
      else pass_cnt++;
      next_cycle();
    end
  endtask

  task automatic test_mem_wait();
    stim_t tbl[6];
    for (int i = 0; i < 3; i++) tbl[i] = '{req:1'b1, ack:1'b0, default:'0};
    tbl[3] = '{req:1'b1, ack:1'b1, default:'0};
    tbl[4] = IDLE;
    tbl[5] = '{rs:5'd4, rt:5'd0, mr:1'b1, xrt:5'd4, default:1'b0};
    for (int i = 0; i < 6; i++) begin
      apply(tbl[i]);
      #1;
      total_cnt++;
      if ({obs, mem_err} !== {model_out(), errored})
        $display("FAIL mem_wait[%0d]: got %b/%b exp %b/%b", i, obs, mem_err, model_out(), errored);
      else pass_cnt++;
      next_cycle();
    end
  endtask

  task automatic test_timeout();
    stim_t tbl[16];
    for (int i = 0; i < 5; i++) tbl[i] = '{req:1'b1, ack:1'b0, default:'0};
    tbl[5]  = '{req:1'b1, ack:1'b1, default:'0};
    tbl[6]  = '{req:1'b0, ack:1'b1, default:'0};
    tbl[7]  = '{clr:1'b1, default:'0};
    tbl[8]  = IDLE;
    tbl[9]  = '{clr:1'b1, default:'0};
    for (int i = 10; i < 14; i++) tbl[i] = '{req:1'b1, ack:1'b0, default:'0};
    tbl[14] = '{req:1'b1, ack:1'b1, default:'0};
    tbl[15] = IDLE;
    for (int i = 0; i < 16; i++) begin
      apply(tbl[i]);
      #1;
      total_cnt++;
      if ({obs, mem_err} !== {model_out(), errored})
        $display("FAIL timeout[%0d]: got %b/%b exp %b/%b", i, obs, mem_err, model_out(), errored);
      else pass_cnt++;
      next_cycle();
    end
  endtask

  task automatic test_async_reset();
    apply('{req:1'b1, ack:1'b0, default:'0});
    #1;
    next_cycle();
    #1;
    total_cnt++;
    if (obs !== model_out()) $display("FAIL async_pre: got %b exp %b", obs, model_out());
    else pass_cnt++;
    model_tick();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_tick();
    #1;
    total_cnt++;
    if ({obs, mem_err} !== {8'b0001_0101, 1'b0})
      $display("FAIL async_forced: got %b/%b exp %b/0", obs, mem_err, 8'b0001_0101);
    else pass_cnt++;
    @(negedge clk);
    apply(IDLE);
    rst_n = 1'b1;
    #1;
    total_cnt++;
    if ({obs, dut.wait_cnt_q} !== {model_out(), 3'd0})
      $display("FAIL async_release: got %b cnt %0d exp %b cnt 0", obs, dut.wait_cnt_q, model_out());
    else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_random();
    stim_t s;
    for (int i = 0; i < 400; i++) begin
      s.rs  = AW'($urandom_range(0, 3));
      s.rt  = AW'($urandom_range(0, 3));
      s.xrt = AW'($urandom_range(0, 3));
      s.mr  = ($urandom_range(0, 1) == 1);
      s.br  = ($urandom_range(0, 3) == 0);
      s.z   = ($urandom_range(0, 1) == 1);
      s.req = ($urandom_range(0, 9) < 3);
      s.ack = ($urandom_range(0, 9) < 4);
      s.clr = ($urandom_range(0, 4) == 0);
      apply(s);
      #1;
      total_cnt++;
      if ({obs, mem_err} !== {model_out(), errored})
        $display("FAIL random[%0d]: got %b/%b exp %b/%b", i, obs, mem_err, model_out(), errored);
      else pass_cnt++;
      next_cycle();
    end
`ifdef HAZARD_PERF_CNT_EN
    total_cnt++;
    if ({stall_cycles, lu_stalls, br_flushes} !== {m_stall, m_lu, m_br})
      $display("FAIL random_perf: got %0d/%0d/%0d exp %0d/%0d/%0d",
               stall_cycles, lu_stalls, br_flushes, m_stall, m_lu, m_br);
    else pass_cnt++;
`endif
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf();
    stim_t tbl[10];
    rst_n = 1'b0;
    apply(IDLE);
    next_cycle();
    rst_n = 1'b1;
    tbl[0] = '{rs:5'd5, rt:5'd0, mr:1'b1, xrt:5'd5, default:1'b0};
    tbl[1] = IDLE;
    tbl[2] = '{rs:5'd1, rt:5'd2, mr:1'b1, xrt:5'd2, default:1'b0};
    tbl[3] = IDLE;
    tbl[4] = '{br:1'b1, z:1'b1, default:'0};
    tbl[5] = IDLE;
    tbl[6] = '{req:1'b1, ack:1'b0, default:'0};
    tbl[7] = '{req:1'b1, ack:1'b0, default:'0};
    tbl[8] = '{req:1'b1, ack:1'b0, default:'0};
    tbl[9] = '{req:1'b1, ack:1'b1, default:'0};
    for (int i = 0; i < 10; i++) begin
      apply(tbl[i]);
      #1;
      total_cnt++;
      if (obs !== model_out()) $display("FAIL perf_seq[%0d]: got %b exp %b", i, obs, model_out());
      else pass_cnt++;
      next_cycle();
    end
    apply(IDLE);
    #1;
    total_cnt++;
    if ({stall_cycles, lu_stalls, br_flushes} !== {32'd5, 32'd2, 32'd1})
      $display("FAIL perf_counts: got %0d/%0d/%0d exp 5/2/1", stall_cycles, lu_stalls, br_flushes);
    else pass_cnt++;
    next_cycle();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    apply(IDLE);
    waiting = 0; errored = 0; waited = 0;
    m_stall = 0; m_lu = 0; m_br = 0;
    @(negedge clk);
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_async_reset();
    test_random();
`ifdef HAZARD_PERF_CNT_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives enable and flush controls of the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Handles three cases: load-use hazards, taken branches resolved in MEM (from the EX/MEM zero flag), and a multi-cycle data-memory handshake with timeout.
- Sits beside the datapath; only control outputs leave it.

Parameters:
- MEM_TIMEOUT, 16, max cycles MEM_WAIT may last before error (>=2).
- REG_AW, 5, register-specifier width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_rs  in  REG_AW  rs of instruction in ID.
- id_rt  in  REG_AW  rt of instruction in ID.
- idex_memread  in  1  instruction in EX is a load.
- idex_rt  in  REG_AW  load destination in EX.
- exmem_branch  in  1  instruction in MEM is a branch.
- exmem_zero  in  1  zero flag latched in EX/MEM.
- exmem_mem_req  in  1  instruction in MEM accesses data memory.
- mem_ack  in  1  data memory done this cycle.
- err_clr  in  1  single-cycle pulse; leave MEM_ERR.
- pc_en  out  1  PC update enable.
- pc_sel_branch  out  1  select branch target into PC.
- ifid_en  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID synchronous clear.
- idex_en  out  1  ID/EX load enable.
- idex_flush  out  1  ID/EX synchronous clear (bubble).
- exmem_en  out  1  EX/MEM load enable.
- exmem_flush  out  1  EX/MEM synchronous clear.
- mem_err  out  1  memory timeout error (sticky).

Behaviour:
- All control outputs are combinational from state and inputs (same-cycle effect). state, wait_cnt and mem_err are registers.
- While rst=0:
  - state=RUN, wait_cnt=0, mem_err=0.
  - Outputs forced: all *_en=0, all *_flush=1, pc_sel_branch=0.
- Reset asserted mid-operation aborts any wait or error immediately.
- Default in RUN: all *_en=1, all *_flush=0, pc_sel_branch=0.
- States: RUN, MEM_WAIT, MEM_ERR. wait_cnt width = $clog2(MEM_TIMEOUT)+1.
- Priority in RUN, highest first:
  1. Memory stall: exmem_mem_req=1 and mem_ack=0.
     - All *_en=0, flushes 0. Next state MEM_WAIT, wait_cnt<=1.
     - If mem_ack=1 in the same cycle: no stall, remain RUN.
  2. Taken branch: exmem_branch=1 and exmem_zero=1.
     - pc_sel_branch=1; ifid_flush=1, idex_flush=1, exmem_flush=1.
     - Enables stay 1. One cycle only; no state change.
     - Any simultaneous load-use is ignored; the flushed instruction dies.
  3. Load-use: idex_memread=1, idex_rt!=0, and (idex_rt==id_rs or idex_rt==id_rt).
     - pc_en=0, ifid_en=0, idex_flush=1. Exactly one bubble per hazard.
- MEM_WAIT:
  - All *_en=0, no flush, wait_cnt increments each cycle.
  - On mem_ack=1: enables return to 1 in that same cycle, state<=RUN, wait_cnt<=0. Branch/load-use rules are evaluated that cycle as in RUN.
  - If wait_cnt==MEM_TIMEOUT and mem_ack=0: state<=MEM_ERR, mem_err<=1.
  - Ack and timeout in the same cycle: ack wins, no error.
- MEM_ERR:
  - All *_en=0; mem_err=1; ack is ignored.
  - On err_clr=1: exmem_flush=1 for that cycle (faulting op dropped), mem_err<=0, state<=RUN, wait_cnt<=0.
  - err_clr outside MEM_ERR has no effect.
- Register 0 never causes a load-use stall.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, adds three 32-bit outputs, reset to 0, each wrapping at 2^32:
  - stall_cycles: +1 per cycle with pc_en=0 outside reset.
  - lu_stalls: +1 per load-use bubble.
  - br_flushes: +1 per taken branch.
- When undefined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Load-use: idex_memread=1, idex_rt=5, id_rs=5 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle; all defaults next cycle. Repeat with idex_rt=0 -> no stall.
- Branch: exmem_branch=1, exmem_zero=1 with a concurrent load-use match -> pc_sel_branch=1, three flushes=1, pc_en=1, no bubble; exmem_zero=0 -> defaults.
- Memory wait: exmem_mem_req=1, mem_ack low 3 cycles then high -> enables 0 for 3 cycles, 1 in the ack cycle, state RUN after; mem_err stays 0.
- Timeout: MEM_TIMEOUT=4, ack never -> mem_err=1 after the 4th wait cycle, enables stay 0; err_clr pulse -> exmem_flush=1 one cycle, mem_err=0, defaults after. Ack coinciding with wait_cnt==4 -> no error.
- Async reset: drop rst mid-MEM_WAIT between clock edges -> outputs forced immediately (enables 0, flushes 1). Release rst -> RUN defaults, wait_cnt=0.
- HAZARD_PERF_CNT_EN: 2 load-use bubbles, 1 branch, 3-cycle memory wait -> lu_stalls=2, br_flushes=1, stall_cycles=5.
